// File: rtl/e1_tx_framer.sv
// E1 transmit framer: builds G.704 TS0 (FAS/NFAS, optional CRC-4 multiframe)
// and interleaves requested payload bytes into a serial line bit stream.
module e1_tx_framer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_ack,
    output logic       in_req,
    output logic [4:0] in_ts,
    output logic [3:0] in_frame,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ack,
    input  logic       ctrl_crc4_en,
    input  logic       ctrl_alarm,
    input  logic [1:0] ctrl_e,
    output logic       status_underflow,
    output logic       status_frame,
    output logic       status_mframe
);

    // position of the bit currently on out_bit
    logic [3:0] frame_q;
    logic [4:0] ts_q;
    logic [2:0] bit_q;
    logic [7:0] sh_q;
    logic       valid_q;

    logic [3:0] crc_q;
    logic [3:0] c_q;

    logic [7:0] buf_q;
    logic       buf_full_q;
    logic       req_q;
    logic [4:0] req_ts_q;
    logic [3:0] req_frame_q;

    logic       uf_q;
    logic       sf_q;
    logic       smf_q;

    logic       adv;
    logic       byte_end;
    logic       load;
    logic [4:0] lts;
    logic [3:0] lframe;
    logic       c_pos;
    logic       fb;
    logic [3:0] crc_step;
    logic       smf_end;
    logic [3:0] c_eff;
    logic       req_take;
    logic [7:0] mfas;
    logic       sbit;
    logic [7:0] ts0_byte;
    logic       underflow;
    logic [7:0] load_byte;

    always_comb begin
        adv      = valid_q & out_ack;
        byte_end = adv & (bit_q == 3'd7);
        load     = ~valid_q | byte_end;

        // the very first load after reset is always frame 0 TS0
        if (!valid_q) begin
            lts    = 5'd0;
            lframe = 4'd0;
        end else begin
            lts    = ts_q + 5'd1;
            lframe = (ts_q == 5'd31) ? frame_q + 4'd1 : frame_q;
        end

        // C-bit slots are fed to the CRC as zero
        c_pos    = (ts_q == 5'd0) && (bit_q == 3'd0) && !frame_q[0];
        fb       = (sh_q[7] & ~c_pos) ^ crc_q[3];
        crc_step = {crc_q[2:0], 1'b0} ^ {2'b00, fb, fb};
        smf_end  = byte_end && (ts_q == 5'd31) && (frame_q[2:0] == 3'd7);

        // frame 0/8 TS0 loads in the same cycle the C register latches
        c_eff    = smf_end ? crc_step : c_q;

        req_take = req_q & in_ack;

        // MFAS 001011 then E bits, indexed by odd-frame number / 2
        mfas = {ctrl_e[0], ctrl_e[1], 6'b110100};
        if (!ctrl_crc4_en)
            sbit = 1'b1;
        else if (lframe[0])
            sbit = mfas[lframe[3:1]];
        else
            sbit = c_eff[~lframe[2:1]];

        if (lframe[0])
            ts0_byte = {sbit, 1'b1, ctrl_alarm, 5'b11111};
        else
            ts0_byte = {sbit, 7'b0011011};

        underflow = 1'b0;
        if (lts == 5'd0)
            load_byte = ts0_byte;
        else if (buf_full_q)
            load_byte = buf_q;
        else if (req_take)
            load_byte = in_data;
        else begin
            load_byte = 8'hFF;
            underflow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_q     <= 4'd0;
            ts_q        <= 5'd0;
            bit_q       <= 3'd0;
            sh_q        <= 8'd0;
            valid_q     <= 1'b0;
            crc_q       <= 4'd0;
            c_q         <= 4'd0;
            buf_q       <= 8'd0;
            buf_full_q  <= 1'b0;
            req_q       <= 1'b0;
            req_ts_q    <= 5'd1;
            req_frame_q <= 4'd0;
            uf_q        <= 1'b0;
            sf_q        <= 1'b0;
            smf_q       <= 1'b0;
        end else begin
            uf_q  <= 1'b0;
            sf_q  <= 1'b0;
            smf_q <= 1'b0;

            if (adv) begin
                crc_q <= smf_end ? 4'd0 : crc_step;
                if (smf_end)
                    c_q <= crc_step;
            end

            if (load) begin
                frame_q <= lframe;
                ts_q    <= lts;
                bit_q   <= 3'd0;
                sh_q    <= load_byte;
                valid_q <= 1'b1;
                if (lts == 5'd0) begin
                    sf_q  <= 1'b1;
                    smf_q <= (lframe == 4'd0);
                end else begin
                    buf_full_q <= 1'b0;
                    uf_q       <= underflow;
                end
                // a new request replaces any unanswered one for the slot just loaded
                if (lts != 5'd31) begin
                    req_q       <= 1'b1;
                    req_ts_q    <= lts + 5'd1;
                    req_frame_q <= lframe;
                end else begin
                    req_q <= 1'b0;
                end
            end else begin
                if (adv) begin
                    bit_q <= bit_q + 3'd1;
                    sh_q  <= {sh_q[6:0], 1'b0};
                end
                if (req_take) begin
                    buf_q      <= in_data;
                    buf_full_q <= 1'b1;
                    req_q      <= 1'b0;
                end
            end
        end
    end

    assign out_bit          = sh_q[7];
    assign out_valid        = valid_q;
    assign in_req           = req_q;
    assign in_ts            = req_ts_q;
    assign in_frame         = req_frame_q;
    assign status_underflow = uf_q;
    assign status_frame     = sf_q;
    assign status_mframe    = smf_q;

endmodule

// File: tb/tb_e1_tx_framer.sv
// Directed bench for e1_tx_framer: TS0 patterns, payload path, CRC-4 C bits,
// stalled output handshake and reset behaviour.
module tb_e1_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data;
    logic       in_ack;
    logic       in_req;
    logic [4:0] in_ts;
    logic [3:0] in_frame;
    logic       out_bit;
    logic       out_valid;
    logic       out_ack;
    logic       ctrl_crc4_en;
    logic       ctrl_alarm;
    logic [1:0] ctrl_e;
    logic       status_underflow;
    logic       status_frame;
    logic       status_mframe;

    e1_tx_framer dut (
        .clk              (clk),
        .rst              (rst),
        .in_data          (in_data),
        .in_ack           (in_ack),
        .in_req           (in_req),
        .in_ts            (in_ts),
        .in_frame         (in_frame),
        .out_bit          (out_bit),
        .out_valid        (out_valid),
        .out_ack          (out_ack),
        .ctrl_crc4_en     (ctrl_crc4_en),
        .ctrl_alarm       (ctrl_alarm),
        .ctrl_e           (ctrl_e),
        .status_underflow (status_underflow),
        .status_frame     (status_frame),
        .status_mframe    (status_mframe)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] cap [0:1023];

    // running pulse totals; the main flow takes baselines instead of clearing
    int uf_tot = 0, sf_tot = 0, smf_tot = 0;
    int uf0, sf0, smf0;
    always @(negedge clk) begin
        if (status_underflow === 1'b1) uf_tot++;
        if (status_frame === 1'b1)     sf_tot++;
        if (status_mframe === 1'b1)    smf_tot++;
    end

    // payload source: acks two cycles after seeing a request, data = {0, ts}
    bit resp_en = 1'b0;
    initial begin
        int rcnt;
        rcnt    = 0;
        in_ack  = 1'b0;
        in_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            in_ack = 1'b0;
            if (resp_en && in_req) begin
                if (rcnt == 2) begin
                    in_ack  = 1'b1;
                    in_data = {3'b000, in_ts};
                    rcnt    = 0;
                end else rcnt++;
            end else rcnt = 0;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tg);
        step();
        rst = 1'b0;
        repeat (2) step();
        chk({tg, "_rst_outs"}, {out_valid, out_bit, in_req, status_underflow,
                                status_frame, status_mframe}, 32'd0);
        chk({tg, "_rst_req"}, {in_ts, in_frame}, {5'd1, 4'd0});
        rst  = 1'b1;
        uf0  = uf_tot;
        sf0  = sf_tot;
        smf0 = smf_tot;
        step();
        chk({tg, "_first_load"}, {out_valid, in_req, status_frame, status_mframe, in_ts, in_frame},
            {1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 4'd0});
    endtask

    task automatic cap_bytes(input int n, input int base);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                b = {b[6:0], out_bit};
                step();
            end
            cap[base + i] = b;
        end
    endtask

    // long-division CRC-4 of one captured SMF, C-bit slots forced to 0
    function automatic logic [3:0] crc_smf(input int s);
        logic [4:0] r;
        logic       b;
        r = 5'd0;
        for (int k = 0; k < 256; k++)
            for (int j = 7; j >= 0; j--) begin
                b = cap[s * 256 + k][j];
                if ((k % 32 == 0) && ((k / 32) % 2 == 0) && (j == 7)) b = 1'b0;
                r = {r[3:0], b};
                if (r[4]) r = r ^ 5'b10011;
            end
        for (int j = 0; j < 4; j++) begin
            r = {r[3:0], 1'b0};
            if (r[4]) r = r ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    initial begin
        int errs;
        int n;
        int cyc;
        logic a;
        logic prev_bit;
        logic prev_ack;
        logic [7:0] rb;

        out_ack      = 1'b1;
        ctrl_crc4_en = 1'b1;
        ctrl_alarm   = 1'b0;
        ctrl_e       = 2'b11;

        // payload responder, CRC-4 on, two full multiframes
        resp_en = 1'b1;
        do_reset("pay");
        cap_bytes(1024, 0);
        chk("pay_underflows", uf_tot - uf0, 0);
        chk("pay_frame_pulses", sf_tot - sf0, 32);
        chk("pay_mframe_pulses", smf_tot - smf0, 2);
        errs = 0;
        for (int f = 0; f < 32; f++)
            for (int t = 1; t < 32; t++)
                if (cap[f * 32 + t] != t[7:0]) errs++;
        chk("pay_ts_content", errs, 0);
        chk("pay_fas_low7", {25'd0, cap[0][6:0]}, 32'h1B);
        chk("pay_first_smf_c", {cap[0][7], cap[64][7], cap[128][7], cap[192][7]}, 4'b0000);
        for (int s = 0; s < 3; s++)
            chk($sformatf("pay_crc_smf%0d", s),
                {cap[(8 * s + 8) * 32][7], cap[(8 * s + 10) * 32][7],
                 cap[(8 * s + 12) * 32][7], cap[(8 * s + 14) * 32][7]},
                crc_smf(s));

        // random output stalls must reproduce the same stream
        do_reset("ack");
        n = 0; cyc = 0; errs = 0; n_chk = n_chk;
        prev_bit = 1'b0; prev_ack = 1'b1;
        begin
            int stall_err;
            stall_err = 0;
            while (n < 512 && cyc < 5000) begin
                a = 1'($urandom_range(0, 1));
                out_ack = a;
                if (!prev_ack && out_bit != prev_bit) stall_err++;
                if (a) begin
                    rb = cap[n / 8];
                    if (out_bit != rb[7 - (n % 8)]) errs++;
                    n++;
                end
                prev_bit = out_bit;
                prev_ack = a;
                step();
                cyc++;
            end
            chk("ack_bits_done", n, 512);
            chk("ack_stream_match", errs, 0);
            chk("ack_hold_stable", stall_err, 0);
        end
        out_ack = 1'b1;

        // reset in the middle of TS17
        do_reset("mid");
        repeat (17 * 8 + 3) step();
        do_reset("mid2");
        cap_bytes(1, 0);
        chk("mid_first_byte", cap[0], 8'h1B);

        // no payload source: underflow fill, CRC-4 TS0 patterns
        resp_en = 1'b0;
        do_reset("uf");
        cap_bytes(32, 0);
        chk("uf_ts0_f0", cap[0], 8'h1B);
        errs = 0;
        for (int t = 1; t < 32; t++) if (cap[t] != 8'hFF) errs++;
        chk("uf_fill_ff", errs, 0);
        chk("uf_pulses_f0", uf_tot - uf0, 31);
        cap_bytes(480, 32);
        chk("crc_c0_f246", {cap[64], cap[128], cap[192]}, {3{8'h1B}});
        chk("mfas_f1", cap[32], 8'h5F);
        chk("mfas_f3", cap[96], 8'h5F);
        chk("mfas_f5", cap[160], 8'hDF);
        chk("e_f13_f15", {cap[416], cap[480]}, {8'hDF, 8'hDF});
        ctrl_alarm = 1'b1;
        cap_bytes(64, 512);
        chk("alarm_f1", cap[544], 8'h7F);

        // plain FAS/NFAS mode
        ctrl_crc4_en = 1'b0;
        ctrl_alarm   = 1'b0;
        do_reset("plain");
        cap_bytes(64, 0);
        chk("plain_even", cap[0], 8'h9B);
        chk("plain_odd", cap[32], 8'hDF);
        ctrl_alarm = 1'b1;
        cap_bytes(64, 64);
        chk("plain_even_alarm", cap[64], 8'h9B);
        chk("plain_odd_alarm", cap[96], 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/e1_tx_framer.md
E1_TX_FRAMER -- requirements
Module: e1_tx_framer

Interface
REQ-001 SHALL have parameter none; all configuration via ctrl_* inputs.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset, synchronous, active-low: asserted when 0, sampled on rising clk.
REQ-004 in_data  in  8  payload byte for timeslot in_ts, bit 1 = MSB.
REQ-005 in_ack  in  1  in_data valid; completes the pending request.
REQ-006 in_req  out  1  byte requested for in_ts/in_frame.
REQ-007 in_ts  out  5  requested timeslot, 1..31.
REQ-008 in_frame  out  4  requested frame within multiframe, 0..15.
REQ-009 out_bit  out  1  current line bit, to e1_tx in_bit.
REQ-010 out_valid  out  1  out_bit is meaningful.
REQ-011 out_ack  in  1  consumer took out_bit; advance one bit.
REQ-012 ctrl_crc4_en  in  1  1 = CRC-4 multiframe mode, 0 = plain FAS/NFAS.
REQ-013 ctrl_alarm  in  1  A bit (remote alarm) sent in NFAS.
REQ-014 ctrl_e  in  2  E bits for frames 13 / 15, CRC-4 mode only.
REQ-015 status_underflow  out  1  one-cycle pulse, payload byte missing.
REQ-016 status_frame  out  1  one-cycle pulse, TS0 bit 1 loaded for transmission.
REQ-017 status_mframe  out  1  one-cycle pulse, frame 0 TS0 bit 1 loaded.

Function
REQ-018 SHALL keep counters frame[3:0], ts[4:0], bit[2:0] for the bit currently on out_bit; advance only on a cycle where out_valid & out_ack.
REQ-019 Bit order SHALL be MSB first; bit wrap 7->0 advances ts; ts 31->0 advances frame; frame 15->0 wraps.
REQ-020 out_bit SHALL hold stable while out_ack low; ack with out_valid low SHALL be ignored.
REQ-021 out_valid SHALL be 1 from the first cycle after reset release onward; TS0 is generated internally, so no payload stall is possible.
REQ-022 Byte load: SHALL occur in the cycle the 8th bit of a byte is acked; next byte available on out_bit the following cycle (one-cycle latency, no bubble; out_valid stays 1).
REQ-023 TS0, even frames: bit1 = C/Si bit, bits2-8 = 0011011.
REQ-024 TS0, odd frames: bit1 = MFAS/E/Si bit, bit2 = 1, bit3 = ctrl_alarm, bits4-8 = 11111.
REQ-025 CRC-4 mode bit1, odd frames 1,3,5,7,9,11 = 0,0,1,0,1,1; frame 13 = ctrl_e[1]; frame 15 = ctrl_e[0].
REQ-026 CRC-4 mode bit1, even frames 0,2,4,6 = C1..C4 and frames 8,10,12,14 = C1..C4, from the previous sub-multiframe (SMF).
REQ-027 ctrl_crc4_en=0: bit1 = 1 in all frames.
REQ-028 CRC-4, poly x^4+x+1, init 0, bit-serial over all 2048 bits of an SMF (frames 0-7 or 8-15), C-bit positions fed as 0.
REQ-029 At each SMF end (ack of frame 7/15 TS31 bit 8), CRC SHALL latch into C register (C1 = x^3 coefficient) and reset to 0.
REQ-030 C register SHALL reset to 0, so the first SMF after reset sends C=0000.
REQ-031 ctrl_* SHALL be sampled at TS0 load; changes mid-frame take effect next TS0.
REQ-032 Request: in_req rises the cycle after the load of TS k (k=0..30), with in_ts=k+1 and in_frame=frame of TS k+1; no request for TS0.
REQ-033 in_req SHALL stay high until in_ack; in_ack with in_req high stores in_data in a one-byte buffer; in_req low the next cycle.
REQ-034 in_ack with in_req low SHALL be ignored.
REQ-035 Byte load with buffer empty and in_ack high in the same cycle SHALL use in_data directly (bypass).
REQ-036 Byte load for TS1-31 with no byte: SHALL send 0xFF, pulse status_underflow, drop in_req; a later ack for that slot is not accepted.
REQ-037 Payload bytes SHALL be transmitted unmodified and included in the CRC.

Reset
REQ-038 While rst=0: frame=0, ts=0, bit=0, CRC=0, C=0, buffer empty, in_req=0, in_ts=1, in_frame=0, out_valid=0, out_bit=0, status_*=0.
REQ-039 First cycle after release SHALL load frame 0 TS0 and pulse status_frame and status_mframe.
REQ-040 Reset mid-frame SHALL abandon the pending request and restart at frame 0 TS0 bit 1.

Verification
REQ-041 crc4_en=1, out_ack=1, in_ack=0 after reset -> first byte 0x1B (00011011); 31 underflow pulses per frame; TS1-31 = 0xFF.
REQ-042 crc4_en=1, alarm=0 -> frame 1 TS0 = 0x5F, frame 3 = 0x5F, frame 5 = 0xDF; ctrl_e=2'b11 -> frames 13/15 = 0xDF; alarm=1 -> frame 1 = 0x7F.
REQ-043 crc4_en=0 -> even TS0 = 0x9B, odd TS0 = 0xDF; alarm=1 -> odd = 0xFF.
REQ-044 Responder acks 2 cycles after in_req with in_data = {3'b0, in_ts} -> TS n carries n; zero underflows; status_frame every 256 acks; status_mframe every 4096 acks.
REQ-045 out_ack toggled pseudo-randomly -> out_bit stable while out_ack=0; bit stream identical to the continuous-ack case.
REQ-046 Fixed payload over 2 multiframes -> C bits in SMF n+1 match a software CRC-4 model of SMF n; first SMF C = 0000; reset mid-TS17 -> next byte 0x1B.
